// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the core's exception logic.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Address is word aligned and falls inside a 2**aw word array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array: synchronous write, registered read, synchronous clear of every word.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Clear wipes the whole array so a restarted program sees zeroed memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[idx] <= wdata;
      if (re) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory slave: serves each legal load/store after WAIT_CYCLES wait
// states and holds the core off with a combinational stall meanwhile.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [WORD_W-1:0] read_data,
  output logic              stall,
  output logic              addr_err
);

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  mem_state_t state;
  logic [3:0] cnt;
  logic       any_strobe;
  logic       req;
  logic       go_done;
  logic       we;
  logic       re;

  assign any_strobe = MemRead | MemWrite;
  assign req        = (MemRead ^ MemWrite) && addr_ok(address, AW);
  assign addr_err   = any_strobe && !req;

  // Nothing is in flight while reset is held, so the core is never stalled by it.
  assign stall = req && (state != DONE) && !rst;

  // Edge that moves the FSM into DONE; loads capture the array word here.
  assign go_done = req && (((state == IDLE) && (WC == 4'd0)) ||
                           ((state == WAIT) && (cnt == 4'd1)));
  assign re = go_done && MemRead;
  // Store commits on the edge that ends DONE, while the core still holds its inputs.
  assign we = (state == DONE) && req && MemWrite;

  // Access sequencer: IDLE -> (WAIT x WAIT_CYCLES) -> DONE -> IDLE; WAIT aborts if req drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            cnt   <= WC;
            state <= (WC == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!req)              state <= IDLE;
          else if (cnt == 4'd1)  state <= DONE;
          else                   cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .idx   (address[AW+1:2]),
    .wdata (write_data),
    .rdata (read_data)
  );

endmodule
